writeback_stage: RTL and testbench

- Final pipeline stage of the RV32I core. Sits directly upstream of the register file and is the only driver of its write port (w_en/w_addr/w_data).
- Accepts completed results from two producers: the ALU result channel and the load-return channel. It arbitrates between them and performs load byte/half extraction with sign or zero extension.
- Presents one registered write per cycle to the regfile, plus a forwarding copy for the hazard logic.

---
 rtl/writeback_stage.sv | 142 ++++++++++++++
 tb/tb_writeback_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Summary  : RV32I writeback. Arbitrates ALU/load results, formats loads,
//            drives the regfile write port and the forwarding copy.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [4:0]  ld_rd,
   input  logic [31:0] ld_data,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr_lo,
   output logic        w_en,
   output logic [4:0]  w_addr,
   output logic [31:0] w_data,
   output logic        fwd_valid,
   output logic [4:0]  fwd_rd,
   output logic [31:0] fwd_data,
   output logic        ld_err,
   output logic [31:0] retire_count
);

   localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   logic [3:0]  starve_cnt;
   logic        starved;
   logic        alu_fire;
   logic        ld_fire;
   logic        ld_bad;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_fmt;

   // Loads normally win; a starved ALU is force-granted once.
   always_comb begin
      starved   = (starve_cnt == LIMIT);
      alu_ready = 1'b0;
      ld_ready  = 1'b0;
      if (!reset) begin
         if (alu_valid && (!ld_valid || starved))
            alu_ready = 1'b1;
         else if (ld_valid)
            ld_ready = 1'b1;
      end
   end

   assign alu_fire = alu_valid && alu_ready;
   assign ld_fire  = ld_valid && ld_ready;

   always_comb begin
      ld_byte = ld_data[7:0];
      case (ld_addr_lo)
         2'd0:    ld_byte = ld_data[7:0];
         2'd1:    ld_byte = ld_data[15:8];
         2'd2:    ld_byte = ld_data[23:16];
         default: ld_byte = ld_data[31:24];
      endcase
      ld_half = ld_addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
   end

   always_comb begin
      ld_fmt = ld_data;
      ld_bad = 1'b0;
      case (ld_funct3)
         F3_LB:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
         F3_LBU: ld_fmt = {24'd0, ld_byte};
         F3_LH: begin
            ld_fmt = {{16{ld_half[15]}}, ld_half};
            ld_bad = ld_addr_lo[0];
         end
         F3_LHU: begin
            ld_fmt = {16'd0, ld_half};
            ld_bad = ld_addr_lo[0];
         end
         F3_LW: begin
            ld_fmt = ld_data;
            ld_bad = (ld_addr_lo != 2'd0);
         end
         default: begin
            ld_fmt = ld_data;
            ld_bad = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_en         <= 1'b0;
         w_addr       <= 5'd0;
         w_data       <= 32'd0;
         ld_err       <= 1'b0;
         retire_count <= 32'd0;
         starve_cnt   <= 4'd0;
      end else begin
         w_en   <= 1'b0;
         ld_err <= 1'b0;

         if (alu_valid && !alu_ready)
            starve_cnt <= starved ? starve_cnt : starve_cnt + 4'd1;
         else
            starve_cnt <= 4'd0;

         if (alu_fire) begin
            w_en         <= (alu_rd != 5'd0);
            w_addr       <= alu_rd;
            w_data       <= alu_data;
            retire_count <= retire_count + 32'd1;
         end else if (ld_fire) begin
            // Faulting loads leave the previous write address/data in place.
            if (ld_bad) begin
               ld_err <= 1'b1;
            end else begin
               w_en         <= (ld_rd != 5'd0);
               w_addr       <= ld_rd;
               w_data       <= ld_fmt;
               retire_count <= retire_count + 32'd1;
            end
         end
      end
   end

   assign fwd_valid = w_en;
   assign fwd_rd    = w_addr;
   assign fwd_data  = w_data;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// Directed scoreboard bench for writeback_stage: expectations are queued when
// a cycle is driven and checked against the registered outputs a cycle later.
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_valid, ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic [2:0]  ld_funct3;
   logic [1:0]  ld_addr_lo;
   logic        w_en, fwd_valid, ld_err;
   logic [4:0]  w_addr, fwd_rd;
   logic [31:0] w_data, fwd_data, retire_count;

   writeback_stage #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
      .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .ld_err(ld_err), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        en;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        err;
      logic [31:0] cnt;
      logic        chk_ad;
   } exp_t;

   exp_t        sb[$];
   int          passed = 0;
   int          total  = 0;
   logic [4:0]  m_addr = 5'd0;
   logic [31:0] m_data = 32'd0;
   logic [31:0] m_cnt  = 32'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
   endtask

   function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [31:0] d,
                                            input logic [1:0] lo);
      logic [7:0]  b;
      logic [15:0] h;
      b = d[8*lo +: 8];
      h = lo[1] ? d[31:16] : d[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'd0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'd0, h};
         default: return d;
      endcase
   endfunction

   function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] lo);
      case (f3)
         3'b000, 3'b100: return 1'b0;
         3'b001, 3'b101: return lo[0];
         3'b010:         return lo != 2'd0;
         default:        return 1'b1;
      endcase
   endfunction

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) return;
      e = sb.pop_front();
      chk("w_en", 32'(w_en), 32'(e.en));
      chk("fwd_valid", 32'(fwd_valid), 32'(e.en));
      chk("ld_err", 32'(ld_err), 32'(e.err));
      chk("retire_count", retire_count, e.cnt);
      if (e.chk_ad) begin
         chk("w_addr", 32'(w_addr), 32'(e.addr));
         chk("w_data", w_data, e.data);
         chk("fwd_rd", 32'(fwd_rd), 32'(e.addr));
         chk("fwd_data", fwd_data, e.data);
      end
   endtask

   // g: 0 = no grant expected, 1 = ALU grant, 2 = load grant
   task automatic step(input logic rst, input logic av, input logic [4:0] ard,
                       input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                       input logic [31:0] ldd, input logic [2:0] f3, input logic [1:0] lo,
                       input int g);
      exp_t e;
      @(negedge clk);
      check_out();
      reset = rst; alu_valid = av; alu_rd = ard; alu_data = ad;
      ld_valid = lv; ld_rd = lrd; ld_data = ldd; ld_funct3 = f3; ld_addr_lo = lo;
      #1;
      chk("alu_ready", 32'(alu_ready), 32'(g == 1));
      chk("ld_ready", 32'(ld_ready), 32'(g == 2));
      e = '0;
      e.chk_ad = 1'b1;
      if (rst) begin
         m_addr = 5'd0; m_data = 32'd0; m_cnt = 32'd0;
      end else if (g == 1) begin
         m_addr = ard; m_data = ad; m_cnt = m_cnt + 32'd1;
         e.en = (ard != 5'd0);
      end else if (g == 2) begin
         if (load_bad(f3, lo)) begin
            e.err = 1'b1;
            e.chk_ad = 1'b0;
         end else begin
            m_addr = lrd; m_data = fmt_load(f3, ldd, lo); m_cnt = m_cnt + 32'd1;
            e.en = (lrd != 5'd0);
         end
      end
      e.addr = m_addr; e.data = m_data; e.cnt = m_cnt;
      sb.push_back(e);
   endtask

   task automatic flush();
      @(negedge clk);
      check_out();
      alu_valid = 1'b0; ld_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; alu_valid = 1'b0; ld_valid = 1'b0; alu_rd = '0; alu_data = '0;
      ld_rd = '0; ld_data = '0; ld_funct3 = '0; ld_addr_lo = '0;

      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 3, 32'h1, 1, 4, 32'h2, 3'b010, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // load extension set
      step(0, 0, 0, 0, 1, 6, 32'h80FF_7F01, 3'b000, 2'd3, 2);
      step(0, 0, 0, 0, 1, 7, 32'h80FF_7F01, 3'b100, 2'd1, 2);
      step(0, 0, 0, 0, 1, 8, 32'h80FF_7F01, 3'b001, 2'd2, 2);
      step(0, 0, 0, 0, 1, 9, 32'h80FF_7F01, 3'b101, 2'd0, 2);
      step(0, 0, 0, 0, 1, 10, 32'h80FF_7F01, 3'b010, 2'd0, 2);

      // contention: L,L,L,L,A repeating
      for (int i = 0; i < 10; i++)
         step(0, 1, 5'(11 + i), 32'hA000_0000 + i, 1, 5'(1 + i), 32'hB000_0000 + i,
              3'b010, 2'd0, (i % 5 == 4) ? 1 : 2);

      // x0 writes and faulting loads
      step(0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1, 12, 32'hCAFE_F00D, 3'b010, 2'd2, 2);
      step(0, 0, 0, 0, 1, 13, 32'hCAFE_F00D, 3'b011, 2'd0, 2);
      step(0, 0, 0, 0, 1, 14, 32'hCAFE_F00D, 3'b101, 2'd1, 2);
      step(0, 0, 0, 0, 1, 0, 32'h0000_00FF, 3'b100, 2'd0, 2);

      // reset while both channels are valid
      step(0, 1, 15, 32'h1, 1, 16, 32'h2, 3'b010, 0, 2);
      step(0, 1, 15, 32'h1, 1, 16, 32'h2, 3'b010, 0, 2);
      step(1, 1, 15, 32'h1, 1, 16, 32'h2, 3'b010, 0, 0);
      step(0, 1, 17, 32'h3, 1, 18, 32'h4, 3'b010, 0, 2);
      chk("starve_after_reset", 32'(dut.starve_cnt), 32'd0);
      for (int i = 0; i < 4; i++)
         step(0, 1, 17, 32'h3, 1, 18, 32'h5 + i, 3'b010, 0, (i == 3) ? 1 : 2);
      flush();

      // counter wrap
      dut.retire_count = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 19, 32'h5555_AAAA, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      flush();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
